// File: rtl/rat_int_pkg.sv
// Shared types and helpers for the RAT CPU interrupt controller.
package rat_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_e;

    // Source-ID width; never narrower than one bit so the port stays legal.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rat_int_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request is set and which one wins.
module rat_int_prio_enc #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rat_int_ctrl.sv
// Interrupt controller/arbiter for the RAT CPU: edge-latched, masked, fixed-priority requests
// with INT/ACK/RETI handshake and the global interrupt-enable flag.
module rat_int_ctrl
    import rat_int_pkg::*;
#(
    parameter int unsigned      N_SRC    = 4,
    parameter int unsigned      ID_W     = id_w(N_SRC),
    parameter logic [N_SRC-1:0] MASK_RST = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_i,
    input  logic             mask_wr_i,
    input  logic [N_SRC-1:0] mask_din_i,
    input  logic             i_set_i,
    input  logic             i_clr_i,
    input  logic             int_ack_i,
    input  logic             reti_i,
    input  logic             reti_ie_i,
    output logic             int_o,
    output logic [ID_W-1:0]  int_id_o,
    output logic             ie_o,
    output logic             in_service_o,
    output logic [N_SRC-1:0] pending_o,
    output logic [N_SRC-1:0] mask_o
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic               ie_q, ie_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   irq_q;
    logic [N_SRC-1:0]   rise;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;

    assign rise = irq_i & ~irq_q;

    rat_int_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (pending_q & mask_q),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    always_comb begin
        state_d   = state_q;
        int_id_d  = int_id_q;
        ie_d      = ie_q;
        pending_d = pending_q | rise;
        mask_d    = mask_wr_i ? mask_din_i : mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_clr_i) begin
                    ie_d = 1'b0;
                end else if (i_set_i) begin
                    ie_d = 1'b1;
                end
                if (ie_q && enc_valid) begin
                    state_d  = ST_REQ;
                    int_id_d = enc_id;
                end
            end
            ST_REQ: begin
                if (int_ack_i) begin
                    state_d   = ST_SVC;
                    ie_d      = 1'b0;
                    // A fresh edge on the acknowledged source re-pends it in the same cycle.
                    pending_d = (pending_q & ~(N_SRC'(1) << int_id_q)) | rise;
                end else if (i_clr_i) begin
                    state_d = ST_IDLE;
                    ie_d    = 1'b0;
                end else if (i_set_i) begin
                    ie_d = 1'b1;
                end
            end
            ST_SVC: begin
                if (reti_i) begin
                    state_d = ST_IDLE;
                    ie_d    = reti_ie_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            int_id_q  <= '0;
            ie_q      <= 1'b0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            irq_q     <= '0;
        end else begin
            state_q   <= state_d;
            int_id_q  <= int_id_d;
            ie_q      <= ie_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_i;
        end
    end

    assign int_o        = (state_q == ST_REQ);
    assign in_service_o = (state_q == ST_SVC);
    assign int_id_o     = int_id_q;
    assign ie_o         = ie_q;
    assign pending_o    = pending_q;
    assign mask_o       = mask_q;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Self-checking bench for rat_int_ctrl: per-cycle vector table with a queue-based scoreboard.
module tb_rat_int_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq, mask_din, pending, mask;
    logic         mask_wr, i_set, i_clr, int_ack, reti, reti_ie;
    logic         int_req, ie, in_service;
    logic [W-1:0] int_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] irq;
        logic         mwr;
        logic [N-1:0] mdin;
        logic         set, clr, ack, reti, rie;
        logic         e_int;
        logic [W-1:0] e_id;
        logic         e_ie, e_svc;
        logic [N-1:0] e_pend, e_mask;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    rat_int_ctrl #(.N_SRC(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_i        (irq),
        .mask_wr_i    (mask_wr),
        .mask_din_i   (mask_din),
        .i_set_i      (i_set),
        .i_clr_i      (i_clr),
        .int_ack_i    (int_ack),
        .reti_i       (reti),
        .reti_ie_i    (reti_ie),
        .int_o        (int_req),
        .int_id_o     (int_id),
        .ie_o         (ie),
        .in_service_o (in_service),
        .pending_o    (pending),
        .mask_o       (mask)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [N-1:0] i, input logic mw, input logic [N-1:0] md,
                       input logic s, input logic c, input logic a, input logic r,
                       input logic ri, input logic ei, input logic [W-1:0] eid,
                       input logic eie, input logic esv, input logic [N-1:0] ep,
                       input logic [N-1:0] em);
        vec_t v;
        v.irq = i; v.mwr = mw; v.mdin = md; v.set = s; v.clr = c; v.ack = a;
        v.reti = r; v.rie = ri; v.e_int = ei; v.e_id = eid; v.e_ie = eie;
        v.e_svc = esv; v.e_pend = ep; v.e_mask = em;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".int"}, 32'(int_req), 32'(e.e_int));
        if (e.e_int) chk({tag, ".id"}, 32'(int_id), 32'(e.e_id));
        chk({tag, ".ie"}, 32'(ie), 32'(e.e_ie));
        chk({tag, ".svc"}, 32'(in_service), 32'(e.e_svc));
        chk({tag, ".pend"}, 32'(pending), 32'(e.e_pend));
        chk({tag, ".mask"}, 32'(mask), 32'(e.e_mask));
    endtask

    initial begin
        vec_t e;
        rst_n = 1'b0; irq = '0; mask_wr = 0; mask_din = '0; i_set = 0; i_clr = 0;
        int_ack = 0; reti = 0; reti_ie = 0;

        //   irq    mwr mdin   set clr ack rti rie | int id ie svc pend   mask
        // IE=0 pend, then SEI
        add(4'b0010, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0010, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0010, 4'hF);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0010, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 4'b0010, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0000, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b0000, 4'hF);
        // Two sources together; back-to-back after RETIE
        add(4'b1010, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b1010, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 4'b1010, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b1000, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b1000, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 3, 1, 0, 4'b1000, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0000, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b0000, 4'hF);
        // No preemption in REQ
        add(4'b0100, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0100, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 2, 1, 0, 4'b0100, 4'hF);
        add(4'b0001, 0, 4'h0, 0, 0, 0, 0, 0,   1, 2, 1, 0, 4'b0101, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 2, 1, 0, 4'b0101, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0000, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b0000, 4'hF);
        // Masking, then unmask
        add(4'b0000, 1, 4'hE, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0000, 4'hE);
        add(4'b0001, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0001, 4'hE);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0001, 4'hE);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0001, 4'hE);
        add(4'b0000, 1, 4'hF, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4'b0001, 4'hF);
        // CLI in REQ, ACK+CLI, edge during ACK clear, SEI ignored in SVC, RETID
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4'b0001, 4'hF);
        add(4'b0001, 0, 4'h0, 0, 1, 1, 0, 0,   0, 0, 0, 1, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 4'b0001, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0001, 4'hF);
        // Held-high IRQ does not re-pend
        add(4'b0010, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0011, 4'hF);
        add(4'b0010, 0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0011, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 4'b0011, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0010, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b0010, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 4'b0010, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0000, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 4'b0000, 4'hF);
        add(4'b0010, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0000, 4'hF);
        // SEI+CLI: CLI wins; mask change in REQ does not cancel
        add(4'b0010, 0, 4'h0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 4'b0000, 4'hF);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0000, 4'hF);
        add(4'b0100, 0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 4'b0100, 4'hF);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0,   1, 2, 1, 0, 4'b0100, 4'hF);
        add(4'b0000, 1, 4'hB, 0, 0, 0, 0, 0,   1, 2, 1, 0, 4'b0100, 4'hB);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 4'b0000, 4'hB);

        // Reset state
        #12;
        e = '{irq: '0, mwr: 0, mdin: '0, set: 0, clr: 0, ack: 0, reti: 0, rie: 0,
              e_int: 0, e_id: '0, e_ie: 0, e_svc: 0, e_pend: '0, e_mask: 4'hF};
        chk_all("reset", e);
        chk("reset.id", 32'(int_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            irq = tbl[k].irq; mask_wr = tbl[k].mwr; mask_din = tbl[k].mdin;
            i_set = tbl[k].set; i_clr = tbl[k].clr; int_ack = tbl[k].ack;
            reti = tbl[k].reti; reti_ie = tbl[k].rie;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("v%0d", k), e);
            end
        end

        // Asynchronous reset mid-service, away from any clock edge
        @(negedge clk);
        irq = '0; mask_wr = 0; i_set = 0; i_clr = 0; int_ack = 0; reti = 0; reti_ie = 0;
        chk("pre_rst.svc", 32'(in_service), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        e = '{irq: '0, mwr: 0, mdin: '0, set: 0, clr: 0, ack: 0, reti: 0, rie: 0,
              e_int: 0, e_id: '0, e_ie: 0, e_svc: 0, e_pend: '0, e_mask: 4'hF};
        chk_all("async_rst", e);
        chk("async_rst.id", 32'(int_id), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
